// File: rtl/accumulator_bank_pkg.sv
// accumulator_bank_pkg: shared sizing, operation and word types for the accumulator bank
package accumulator_bank_pkg;
    localparam int P_BITWIDTH = 24;
    localparam int SYS_COLS   = 8;
    localparam int ACC_DEPTH  = 16;
    localparam int ACC_ADDR_W = $clog2(ACC_DEPTH + 1);
    localparam int ACC_IDX_W  = $clog2(ACC_DEPTH);
    localparam int ROW_W      = SYS_COLS * P_BITWIDTH;

    typedef enum logic [1:0] {FILL_OVR, FILL_ACC, DRAIN, OP_RSVD} acc_op_t;
    typedef logic signed [P_BITWIDTH-1:0] acc_word_t;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} acc_state_t;
endpackage

// File: rtl/acc_column.sv
// acc_column: one column of accumulator storage with its own write pointer and read-modify-write adder
module acc_column
    import accumulator_bank_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  wr_i,
    input  logic                  acc_i,
    input  acc_word_t             psum_i,
    input  logic [ACC_ADDR_W-1:0] len_i,
    input  logic [ACC_IDX_W-1:0]  rd_idx_i,
    output acc_word_t             rd_data_o,
    output logic                  full_o
);
    acc_word_t             mem_q [ACC_DEPTH];
    logic [ACC_ADDR_W-1:0] wp_q;
    logic [ACC_IDX_W-1:0]  wr_idx;
    acc_word_t             wr_d;

    assign wr_idx    = ACC_IDX_W'(wp_q);
    assign wr_d      = acc_i ? mem_q[wr_idx] + psum_i : psum_i;
    assign full_o    = wp_q == len_i;
    assign rd_data_o = mem_q[rd_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            for (int i = 0; i < ACC_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (clr_i) wp_q <= '0;
            else if (wr_i) wp_q <= wp_q + ACC_ADDR_W'(1);
            if (wr_i) mem_q[wr_idx] <= wr_d;
        end
    end
endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: captures staggered systolic column psums into row storage and drains rows
// over a valid/ready stream; FSM, row pointer and output register live here, storage per column.
module accumulator_bank
    import accumulator_bank_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ACC_ADDR_W-1:0] cmd_len_i,
    input  logic [SYS_COLS-1:0]   psum_valid_i,
    input  logic [ROW_W-1:0]      psum_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ROW_W-1:0]      out_data_o,
    output logic                  out_last_o,
    output logic                  done_o,
    output logic                  err_o
);
    acc_state_t            state_q, state_d;
    logic [ACC_ADDR_W-1:0] len_q, len_d, rp_q, rp_d;
    logic                  acc_q, acc_d, out_valid_q, out_valid_d, err_q, err_d;
    logic [ROW_W-1:0]      out_data_q, out_data_d, rd_row;
    logic [SYS_COLS-1:0]   wr, full;
    logic [ACC_IDX_W-1:0]  rd_idx;
    logic                  accept, illegal, xfer, last, load;
    acc_op_t               op;

    assign op          = acc_op_t'(cmd_op_i);
    assign cmd_ready_o = state_q == S_IDLE;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign illegal     = op == OP_RSVD || cmd_len_i > ACC_ADDR_W'(ACC_DEPTH);
    assign xfer        = out_valid_q && out_ready_i;
    assign last        = rp_q == len_q - ACC_ADDR_W'(1);
    // Fetch the first row on entry, then prefetch the next row on every transfer to sustain 1 row/cycle
    assign load        = state_q == S_DRAIN && (out_valid_q ? xfer && !last : rp_q != len_q);
    assign rd_idx      = ACC_IDX_W'(xfer ? rp_q + ACC_ADDR_W'(1) : rp_q);
    assign wr          = state_q == S_FILL ? psum_valid_i & ~full : '0;

    for (genvar j = 0; j < SYS_COLS; j++) begin : g_col
        acc_column u_col (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (accept),
            .wr_i      (wr[j]),
            .acc_i     (acc_q),
            .psum_i    (psum_data_i[j*P_BITWIDTH +: P_BITWIDTH]),
            .len_i     (len_q),
            .rd_idx_i  (rd_idx),
            .rd_data_o (rd_row[j*P_BITWIDTH +: P_BITWIDTH]),
            .full_o    (full[j])
        );
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_valid_q && last;
    assign err_o       = err_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        acc_d       = acc_q;
        rp_d        = rp_q;
        out_valid_d = load || (out_valid_q && !xfer);
        out_data_d  = load ? rd_row : out_data_q;
        err_d       = err_q || |(psum_valid_i & ~wr) || (accept && illegal);
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: if (accept && !illegal) begin
                state_d = op == DRAIN ? S_DRAIN : S_FILL;
                len_d   = cmd_len_i;
                acc_d   = op == FILL_ACC;
                rp_d    = '0;
            end
            S_FILL: if (&full) begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                rp_d = rp_q + ACC_ADDR_W'(xfer);
                if (!out_valid_q && rp_q == len_q) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            rp_q        <= '0;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rp_q        <= rp_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: randomized self-checking bench against an array model of the accumulator bank
module tb_accumulator_bank;
    import accumulator_bank_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cmd_valid, cmd_ready, out_valid, out_ready, out_last, done, err;
    logic [1:0]            cmd_op;
    logic [ACC_ADDR_W-1:0] cmd_len;
    logic [SYS_COLS-1:0]   psum_valid;
    logic [ROW_W-1:0]      psum_data, out_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned m [ACC_DEPTH][SYS_COLS];
    int unsigned vals [SYS_COLS][ACC_DEPTH];
    bit          err_m;

    always #5 clk = ~clk;

    accumulator_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_len_i    (cmd_len),
        .psum_valid_i (psum_valid),
        .psum_data_i  (psum_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] row_exp(input int r);
        logic [ROW_W-1:0] w;
        for (int j = 0; j < SYS_COLS; j++) w[j*P_BITWIDTH +: P_BITWIDTH] = P_BITWIDTH'(m[r][j]);
        return w;
    endfunction

    task automatic set_vals(input int mode, input int unsigned k);
        for (int j = 0; j < SYS_COLS; j++)
            for (int r = 0; r < ACC_DEPTH; r++)
                vals[j][r] = mode == 0 ? j * 100 + r : mode == 1 ? k : $urandom & 32'hFFFFFF;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_len    = '0;
        psum_valid = '0;
        psum_data  = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int r = 0; r < ACC_DEPTH; r++)
            for (int j = 0; j < SYS_COLS; j++) m[r][j] = 0;
        err_m = 0;
    endtask

    task automatic send_cmd(input int op, input int len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_len   = ACC_ADDR_W'(len);
        @(negedge clk) check("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Column j starts j cycles late; optional gaps; optional one surplus psum on extra_col
    task automatic run_fill(input int op, input int len, input bit rnd, input int extra_col);
        int r [SYS_COLS];
        int t = 0;
        bit extra_done = 0;
        bit busy;
        foreach (r[j]) r[j] = 0;
        send_cmd(op, len);
        busy = len > 0;
        while (busy && t < 2000) begin
            for (int j = 0; j < SYS_COLS; j++) begin
                bit v;
                v = r[j] < len && t >= j && (!rnd || $urandom_range(0, 3) != 0);
                psum_data[j*P_BITWIDTH +: P_BITWIDTH] = r[j] < len ? P_BITWIDTH'(vals[j][r[j]]) : '0;
                if (j == extra_col && r[j] == len && !extra_done) begin
                    v = 1;
                    extra_done = 1;
                    err_m = 1;
                    psum_data[j*P_BITWIDTH +: P_BITWIDTH] = 24'h5A5A5A;
                end else if (v) begin
                    m[r[j]][j] = op == 1 ? (m[r[j]][j] + vals[j][r[j]]) & 32'hFFFFFF : vals[j][r[j]];
                    r[j]++;
                end
                psum_valid[j] = v;
            end
            t++;
            busy = 0;
            foreach (r[j]) if (r[j] < len) busy = 1;
            @(negedge clk) check("fill_done_early", done, 0);
            @(posedge clk);
            #1;
        end
        psum_valid = '0;
        check("fill_bound", t < 2000, 1);
        @(negedge clk) check("fill_done", done, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("fill_idle", cmd_ready, 1);
        check("fill_done_pulse", done, 0);
        check("fill_err", err, err_m);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_drain(input int len, input int mode);
        int rp = 0;
        int xfers = 0;
        bit fin = 0;
        send_cmd(2, len);
        for (int c = 0; c < 300 && !fin; c++) begin
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("drain_valid", out_valid, c >= 1 && rp < len);
            check("drain_done", done, rp == len);
            fin = rp == len;
            if (out_valid && rp < len) begin
                check("drain_data", out_data, row_exp(rp));
                check("drain_last", out_last, rp == len - 1);
                if (out_ready) begin
                    rp++;
                    xfers++;
                end
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        check("drain_bound", fin, 1);
        check("drain_count", xfers, len);
        @(negedge clk);
        check("drain_idle", cmd_ready, 1);
        check("drain_done_pulse", done, 0);
        check("drain_err", err, err_m);
    endtask

    task automatic illegal_cmd(input int op, input int len);
        err_m = 1;
        send_cmd(op, len);
        repeat (3) begin
            @(negedge clk);
            check("illegal_done", done, 0);
            check("illegal_ready", cmd_ready, 1);
            check("illegal_valid", out_valid, 0);
        end
        check("illegal_err", err, 1);
    endtask

    task automatic psum_in_idle();
        @(posedge clk);
        #1;
        psum_valid = 8'($urandom_range(1, 255));
        psum_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1 psum_valid = '0;
        err_m = 1;
        @(negedge clk) check("idle_psum_err", err, 1);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_out_data", out_data, 0);

        set_vals(0, 0);
        run_fill(0, 10, 0, -1);
        run_drain(10, 0);

        set_vals(1, 1);
        vals[0][0] = 32'h7FFFFF;
        run_fill(1, 10, 0, -1);
        set_vals(1, 1);
        run_fill(1, 10, 0, -1);
        run_drain(10, 0);
        run_drain(4, 1);

        illegal_cmd(0, 17);
        illegal_cmd(3, 5);
        run_drain(10, 2);

        do_reset();
        set_vals(2, 0);
        run_fill(0, 16, 1, -1);
        psum_in_idle();
        run_drain(16, 2);
        run_fill(0, 0, 0, -1);
        run_drain(16, 0);
        run_drain(0, 0);

        do_reset();
        set_vals(0, 0);
        run_fill(0, 10, 0, 0);
        run_drain(10, 0);

        do_reset();
        set_vals(2, 0);
        run_fill(1, 16, 1, -1);
        send_cmd(2, 16);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_out_data", out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b0;
        for (int r = 0; r < ACC_DEPTH; r++)
            for (int j = 0; j < SYS_COLS; j++) m[r][j] = 0;
        err_m = 0;
        @(negedge clk) check("arst_idle", cmd_ready, 1);
        run_drain(16, 2);

        for (int k = 0; k < 6; k++) begin
            set_vals(2, 0);
            run_fill($urandom_range(0, 1), $urandom_range(1, ACC_DEPTH), 1, -1);
            run_drain($urandom_range(0, ACC_DEPTH), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
